// File: rtl/coherence_cache_ctrl.sv
// coherence_cache_ctrl: MSI-style controller for a direct-mapped array with processor, bus and snoop ports
module coherence_cache_ctrl #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 6,
  localparam int ADDR_W = TAG_W + IDX_W,
  localparam int LINES = 2 ** IDX_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [1:0]        bus_msg,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        action,
  output logic [ADDR_W-1:0] action_addr,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_msg,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_wb
);
  typedef enum logic [1:0] {IDLE, COMPARE, BUS} fsm_t;
  localparam logic [1:0] INV = 2'b00, EXC = 2'b01, SHR = 2'b10;
  fsm_t state_q, state_d;
  logic [1:0] st_q [LINES];
  logic [TAG_W-1:0] tag_q [LINES];
  logic req_write_q, pend_hit_q, done_q, hit_q, snoop_wb_q;
  logic [ADDR_W-1:0] req_addr_q, action_addr_q;
  logic [1:0] msg_q, action_q;
  logic [IDX_W-1:0] idx, sidx;
  logic [TAG_W-1:0] tg, stag;
  logic hit, fast, stall, victim, snoop_match;
  logic [1:0] miss_msg;
  assign idx = req_addr_q[IDX_W-1:0];
  assign tg = req_addr_q[ADDR_W-1:IDX_W];
  assign sidx = snoop_addr[IDX_W-1:0];
  assign stag = snoop_addr[ADDR_W-1:IDX_W];
  assign hit = st_q[idx] != INV && tag_q[idx] == tg;
  assign fast = hit && (!req_write_q || st_q[idx] == EXC);
  assign stall = snoop_valid && snoop_msg != 2'b00 && sidx == idx;
  assign victim = !hit && st_q[idx] == EXC;
  assign miss_msg = hit ? 2'b10 : (req_write_q ? 2'b11 : 2'b01);
  assign snoop_match = snoop_valid && snoop_msg != 2'b00 && st_q[sidx] != INV && tag_q[sidx] == stag;
  assign cpu_req_ready = state_q == IDLE;
  assign cpu_done = done_q;
  assign cpu_hit = hit_q;
  assign bus_valid = state_q == BUS;
  assign bus_msg = state_q == BUS ? msg_q : 2'b00;
  assign bus_addr = state_q == BUS ? req_addr_q : '0;
  assign action = action_q;
  assign action_addr = action_addr_q;
  assign snoop_wb = snoop_wb_q;
  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: accept, compare (stalling on same-index snoop), wait for bus accept
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (cpu_req_valid ? COMPARE : IDLE) :
              state_q == COMPARE ? (stall ? COMPARE : (fast ? IDLE : BUS)) :
              (bus_ready ? IDLE : BUS);
  end
  // line array, request latch and output pulses; install is written last so it beats a same-edge snoop
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q <= '{default: INV};
      tag_q <= '{default: '0};
      req_write_q <= 1'b0;
      req_addr_q <= '0;
      pend_hit_q <= 1'b0;
      msg_q <= 2'b00;
      action_q <= 2'b00;
      action_addr_q <= '0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      snoop_wb_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      hit_q <= 1'b0;
      action_q <= 2'b00;
      snoop_wb_q <= snoop_match && st_q[sidx] == EXC && snoop_msg[0];
      if (snoop_match) st_q[sidx] <= snoop_msg == 2'b01 ? SHR : INV;
      if (state_q == IDLE && cpu_req_valid) begin
        req_write_q <= cpu_req_write;
        req_addr_q <= cpu_req_addr;
      end
      if (state_q == COMPARE && !stall) begin
        if (fast) begin
          done_q <= 1'b1;
          hit_q <= 1'b1;
        end else begin
          msg_q <= miss_msg;
          pend_hit_q <= hit;
          if (victim) begin
            action_q <= req_write_q ? 2'b10 : 2'b01;
            action_addr_q <= {tag_q[idx], idx};
          end
        end
      end
      if (state_q == BUS && bus_ready) begin
        st_q[idx] <= req_write_q ? EXC : SHR;
        tag_q[idx] <= tg;
        done_q <= 1'b1;
        hit_q <= pend_hit_q;
      end
    end
  end
endmodule

// File: tb/tb_coherence_cache_ctrl.sv
// tb_coherence_cache_ctrl: directed self-checking bench for coherence_cache_ctrl
module tb_coherence_cache_ctrl;
  logic clock = 1'b0;
  logic reset_n, cpu_req_valid, cpu_req_write, cpu_req_ready, cpu_done, cpu_hit;
  logic bus_valid, bus_ready, snoop_valid, snoop_wb;
  logic [7:0] cpu_req_addr, bus_addr, action_addr, snoop_addr;
  logic [1:0] bus_msg, action, snoop_msg;
  int checks = 0;
  int failures = 0;

  coherence_cache_ctrl #(.IDX_W(2), .TAG_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_msg(bus_msg), .bus_addr(bus_addr),
    .action(action), .action_addr(action_addr),
    .snoop_valid(snoop_valid), .snoop_msg(snoop_msg), .snoop_addr(snoop_addr), .snoop_wb(snoop_wb)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // emsg=00 means a fast hit; otherwise the bus message expected; delay = extra cycles bus_ready stays low
  task automatic txn(input logic wr, input logic [7:0] a, input logic [1:0] emsg, input logic [1:0] eact,
                     input logic [7:0] eaa, input logic ehit, input int delay);
    chk("ready_idle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr = a;
    cyc();
    cpu_req_valid = 1'b0;
    chk("ready_compare", cpu_req_ready, 0);
    cyc();
    if (emsg == 2'b00) begin
      chk("hit_done", cpu_done, 1);
      chk("hit_flag", cpu_hit, ehit);
      chk("hit_no_bus", bus_valid, 0);
    end else begin
      chk("bus_valid", bus_valid, 1);
      chk("bus_msg", bus_msg, emsg);
      chk("bus_addr", bus_addr, a);
      chk("action", action, eact);
      if (eact != 2'b00) chk("action_addr", action_addr, eaa);
      for (int i = 0; i < delay; i++) begin
        cyc();
        chk("hold_valid", bus_valid, 1);
        chk("hold_msg", bus_msg, emsg);
        chk("hold_addr", bus_addr, a);
        chk("hold_no_done", cpu_done, 0);
        chk("action_pulse", action, 0);
      end
      bus_ready = 1'b1;
      cyc();
      bus_ready = 1'b0;
      chk("miss_done", cpu_done, 1);
      chk("miss_hit", cpu_hit, ehit);
      chk("bus_drop", bus_valid, 0);
    end
    cyc();
    chk("done_pulse", cpu_done, 0);
  endtask

  task automatic snoop(input logic [1:0] m, input logic [7:0] a, input logic ewb);
    snoop_valid = 1'b1;
    snoop_msg = m;
    snoop_addr = a;
    cyc();
    snoop_valid = 1'b0;
    snoop_msg = 2'b00;
    chk("snoop_wb", snoop_wb, ewb);
    cyc();
    chk("snoop_wb_pulse", snoop_wb, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr = 8'h00;
    bus_ready = 1'b0;
    snoop_valid = 1'b0;
    snoop_msg = 2'b00;
    snoop_addr = 8'h00;
    cyc();
    cyc();
    chk("rst_done", cpu_done, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_snoop_wb", snoop_wb, 0);
    chk("rst_bus_msg", bus_msg, 0);
    chk("rst_action", action, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_action_addr", action_addr, 0);
    reset_n = 1'b1;
    cyc();
    chk("rst_ready", cpu_req_ready, 1);
    // line1: read miss -> S tag1, read hit, write on S -> E
    txn(1'b0, 8'h05, 2'b01, 2'b00, 8'h00, 1'b0, 0);
    txn(1'b0, 8'h05, 2'b00, 2'b00, 8'h00, 1'b1, 0);
    txn(1'b1, 8'h05, 2'b10, 2'b00, 8'h00, 1'b1, 0);
    // E victim on read miss, then upgrade and E victim on write miss with bus stall
    txn(1'b0, 8'h09, 2'b01, 2'b01, 8'h05, 1'b0, 0);
    txn(1'b1, 8'h09, 2'b10, 2'b00, 8'h00, 1'b1, 0);
    txn(1'b1, 8'h0D, 2'b11, 2'b10, 8'h09, 1'b0, 3);
    txn(1'b1, 8'h0D, 2'b00, 2'b00, 8'h00, 1'b1, 0);
    // line2 E, snoop read miss E->S with wb, snoop write miss S->I without wb
    txn(1'b1, 8'h0A, 2'b11, 2'b00, 8'h00, 1'b0, 0);
    snoop(2'b01, 8'h0A, 1'b1);
    snoop(2'b11, 8'h0A, 1'b0);
    txn(1'b0, 8'h0A, 2'b01, 2'b00, 8'h00, 1'b0, 0);
    // different tag on same index and empty message are ignored
    snoop(2'b11, 8'h06, 1'b0);
    snoop(2'b00, 8'h0A, 1'b0);
    txn(1'b0, 8'h0A, 2'b00, 2'b00, 8'h00, 1'b1, 0);
    // invalidate on E line: no wb, next read misses without victim
    snoop(2'b10, 8'h0D, 1'b0);
    txn(1'b0, 8'h0D, 2'b01, 2'b00, 8'h00, 1'b0, 0);
    // snoop during COMPARE: line1 S tag3 becomes I, write turns into write miss after a stall
    chk("stall_ready_idle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b1;
    cpu_req_addr = 8'h0D;
    cyc();
    cpu_req_valid = 1'b0;
    snoop_valid = 1'b1;
    snoop_msg = 2'b11;
    snoop_addr = 8'h0D;
    cyc();
    snoop_valid = 1'b0;
    snoop_msg = 2'b00;
    chk("stall_ready", cpu_req_ready, 0);
    chk("stall_no_bus", bus_valid, 0);
    chk("stall_snoop_wb", snoop_wb, 0);
    cyc();
    chk("stall_bus_valid", bus_valid, 1);
    chk("stall_bus_msg", bus_msg, 2'b11);
    chk("stall_action", action, 0);
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    chk("stall_done", cpu_done, 1);
    chk("stall_hit", cpu_hit, 0);
    cyc();
    // reset during BUS aborts the request and clears all lines
    chk("abort_ready_idle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr = 8'h11;
    cyc();
    cpu_req_valid = 1'b0;
    cyc();
    chk("abort_bus_valid", bus_valid, 1);
    chk("abort_action", action, 2'b01);
    chk("abort_action_addr", action_addr, 8'h0D);
    reset_n = 1'b0;
    cyc();
    chk("abort_bus_drop", bus_valid, 0);
    chk("abort_no_done", cpu_done, 0);
    chk("abort_action_clr", action, 0);
    reset_n = 1'b1;
    cyc();
    chk("abort_no_done_after", cpu_done, 0);
    txn(1'b0, 8'h0D, 2'b01, 2'b00, 8'h00, 1'b0, 0);
    txn(1'b0, 8'h0A, 2'b01, 2'b00, 8'h00, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
